// File: rtl/select_encoder_32_if.sv
// Handshake bundle for select_encoder_32: select-vector load side plus index valid/ready side.
interface select_encoder_32_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
);
  logic             load_i;
  logic [WIDTH-1:0] vector_i;
  logic [IDX_W-1:0] index_o;
  logic             valid_o;
  logic             ready_i;
  logic [IDX_W:0]   count_o;
  logic             error_o;

  modport master (
    output load_i, vector_i, ready_i,
    input  index_o, valid_o, count_o, error_o
  );

  modport slave (
    input  load_i, vector_i, ready_i,
    output index_o, valid_o, count_o, error_o
  );
endinterface

// File: rtl/select_encoder_32.sv
// Merges one-hot write-select vectors into a pending bitmap and issues register indices lowest-first.
// Define ONEHOT_CHECK_EN to reject loads whose vector is not exactly one-hot (flagged on error_o).
module select_encoder_32 #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input logic               clk_i,
  input logic               rst_i,
  select_encoder_32_if.slave bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pend_q;
  logic [IDX_W-1:0] index_q;
  logic             valid_q;

  logic             hs;
  logic             load_acc;
  logic [WIDTH-1:0] idx_oh;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] pend_nxt;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    lowest_set = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i]) lowest_set = i[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < WIDTH; i++)
      popcount = popcount + (IDX_W+1)'(v[i]);
  endfunction

  assign hs     = valid_q && bus.ready_i;
  assign idx_oh = WIDTH'(1) << index_q;
  // rem deliberately uses the registered bitmap: same-cycle loads wait for the IDLE pass.
  assign rem    = pend_q & ~idx_oh;

`ifdef ONEHOT_CHECK_EN
  logic load_bad;
  logic error_q;

  assign load_bad = bus.load_i && (popcount(bus.vector_i) != (IDX_W+1)'(1));
  assign load_acc = bus.load_i && !load_bad;

  always_ff @(posedge clk_i) begin
    if (rst_i) error_q <= 1'b0;
    else       error_q <= load_bad;
  end

  assign bus.error_o = error_q;
`else
  assign load_acc    = bus.load_i;
  assign bus.error_o = 1'b0;
`endif

  // Load is OR'd in after the clear, so a same-cycle reload of the issued bit keeps it pending.
  assign pend_nxt = (pend_q & ~(hs ? idx_oh : '0)) | (load_acc ? bus.vector_i : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      case (state_q)
        IDLE: begin
          if (pend_q != '0) begin
            index_q <= lowest_set(pend_q);
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (hs) begin
            if (rem != '0) begin
              index_q <= lowest_set(rem);
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.index_o = index_q;
  assign bus.valid_o = valid_q;
  assign bus.count_o = popcount(pend_q);

endmodule

// File: tb/tb_select_encoder_32.sv
// Directed bench for select_encoder_32; expectations follow the ONEHOT_CHECK_EN setting of the build.
module tb_select_encoder_32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  select_encoder_32_if #(.WIDTH(32), .IDX_W(5)) bus ();

  select_encoder_32 #(.WIDTH(32), .IDX_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [4:0] idx,
                           input logic [5:0] cnt, input logic err);
    check({tag, ".valid"}, 32'(bus.valid_o), 32'(v));
    check({tag, ".index"}, 32'(bus.index_o), 32'(idx));
    check({tag, ".count"}, 32'(bus.count_o), 32'(cnt));
    check({tag, ".error"}, 32'(bus.error_o), 32'(err));
  endtask

  initial begin
    rst          = 1'b1;
    bus.load_i   = 1'b1;
    bus.vector_i = 32'hFFFF_FFFF;
    bus.ready_i  = 1'b0;

    // Reset with a load held high: everything must stay cleared.
    step();
    step();
    check_out("rst", 1'b0, 5'd0, 6'd0, 1'b0);
    rst          = 1'b0;
    bus.load_i   = 1'b0;
    bus.vector_i = '0;
    step();
    check_out("rst_rel", 1'b0, 5'd0, 6'd0, 1'b0);

    // Single bit, two-cycle load-to-valid latency.
    bus.ready_i  = 1'b1;
    bus.load_i   = 1'b1;
    bus.vector_i = 32'h0000_0008;
    step();
    bus.load_i   = 1'b0;
    bus.vector_i = '0;
    check_out("single_n", 1'b0, 5'd0, 6'd1, 1'b0);
    step();
    check_out("single_v", 1'b1, 5'd3, 6'd1, 1'b0);
    step();
    check_out("single_done", 1'b0, 5'd3, 6'd0, 1'b0);

    // Multi-bit vector.
    bus.load_i   = 1'b1;
    bus.vector_i = 32'h8000_0021;
    step();
    bus.load_i   = 1'b0;
    bus.vector_i = '0;
`ifdef ONEHOT_CHECK_EN
    check_out("multi_rej", 1'b0, 5'd3, 6'd0, 1'b1);
    step();
    check_out("multi_rej2", 1'b0, 5'd3, 6'd0, 1'b0);
`else
    check_out("multi_n", 1'b0, 5'd3, 6'd3, 1'b0);
    step();
    check_out("multi_0", 1'b1, 5'd0, 6'd3, 1'b0);
    step();
    check_out("multi_5", 1'b1, 5'd5, 6'd2, 1'b0);
    step();
    check_out("multi_31", 1'b1, 5'd31, 6'd1, 1'b0);
    step();
    check_out("multi_done", 1'b0, 5'd31, 6'd0, 1'b0);
`endif

    // Backpressure: a lower bit loaded while 4 is presented must not preempt.
    bus.ready_i  = 1'b0;
    bus.load_i   = 1'b1;
    bus.vector_i = 32'h0000_0010;
    step();
    bus.vector_i = 32'h0000_0001;
    step();
    bus.load_i   = 1'b0;
    bus.vector_i = '0;
    check("bp_idx", 32'(bus.index_o), 32'd4);
    check("bp_cnt", 32'(bus.count_o), 32'd2);
    step();
    check_out("bp_hold", 1'b1, 5'd4, 6'd2, 1'b0);
    bus.ready_i = 1'b1;
    step();
    check_out("bp_0", 1'b1, 5'd0, 6'd1, 1'b0);
    step();
    check_out("bp_done", 1'b0, 5'd0, 6'd0, 1'b0);

    // Collision: reload of bit 3 on its handshake edge keeps it pending, one bubble.
    bus.ready_i  = 1'b0;
    bus.load_i   = 1'b1;
    bus.vector_i = 32'h0000_0008;
    step();
    bus.load_i   = 1'b0;
    bus.vector_i = '0;
    step();
    check_out("col_pres", 1'b1, 5'd3, 6'd1, 1'b0);
    bus.ready_i  = 1'b1;
    bus.load_i   = 1'b1;
    bus.vector_i = 32'h0000_0008;
    step();
    bus.ready_i  = 1'b0;
    bus.load_i   = 1'b0;
    bus.vector_i = '0;
    check_out("col_bubble", 1'b0, 5'd3, 6'd1, 1'b0);
    step();
    check_out("col_again", 1'b1, 5'd3, 6'd1, 1'b0);
    bus.ready_i = 1'b1;
    step();
    check_out("col_done", 1'b0, 5'd3, 6'd0, 1'b0);

    // Two-bit vector 0x3.
    bus.load_i   = 1'b1;
    bus.vector_i = 32'h0000_0003;
    step();
    bus.load_i   = 1'b0;
    bus.vector_i = '0;
`ifdef ONEHOT_CHECK_EN
    check_out("cfg_rej", 1'b0, 5'd3, 6'd0, 1'b1);
    step();
    check_out("cfg_rej2", 1'b0, 5'd3, 6'd0, 1'b0);
    bus.load_i = 1'b1;
    step();
    bus.load_i = 1'b0;
    check_out("cfg_zero", 1'b0, 5'd3, 6'd0, 1'b1);
`else
    check_out("cfg_n", 1'b0, 5'd3, 6'd2, 1'b0);
    step();
    check_out("cfg_0", 1'b1, 5'd0, 6'd2, 1'b0);
    step();
    check_out("cfg_1", 1'b1, 5'd1, 6'd1, 1'b0);
    step();
    check_out("cfg_done", 1'b0, 5'd1, 6'd0, 1'b0);
`endif

    // Mid-operation reset drops pending bits and a same-cycle load.
    bus.ready_i  = 1'b0;
    bus.load_i   = 1'b1;
    bus.vector_i = 32'h0000_0040;
    step();
    bus.vector_i = 32'h0000_0080;
    step();
    check("mid_pres", 32'(bus.index_o), 32'd6);
    rst          = 1'b1;
    bus.vector_i = 32'h0000_0100;
    step();
    rst          = 1'b0;
    bus.load_i   = 1'b0;
    bus.vector_i = '0;
    check_out("mid_rst", 1'b0, 5'd0, 6'd0, 1'b0);
    step();
    check_out("mid_after", 1'b0, 5'd0, 6'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/select_encoder_32.md
# select_encoder_32

Write-select encoder/serializer for the register file. It accepts 32-bit select vectors, the same one-hot form the register-file write decoder produces from a 5-bit selector, and merges them into a pending bitmap. It returns each pending bit as a 5-bit register index over a valid/ready handshake, lowest index first. It sits between select-vector producers (write-back tracking, scoreboard release) and any consumer that needs register addresses one at a time.

## Interface
- WIDTH, 32, number of select lines; must equal 2**IDX_W
- IDX_W, 5, index width
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- load_i  in  1  merge vector_i into the pending bitmap this cycle
- vector_i  in  WIDTH  select bits to enqueue; bit n requests index n
- index_o  out  IDX_W  presented register index, registered
- valid_o  out  1  index_o is valid, registered
- ready_i  in  1  consumer accepts index_o; handshake = valid_o && ready_i
- count_o  out  IDX_W+1  population count of the pending bitmap (0..32)
- error_o  out  1  rejected-load pulse (see Configuration)

## Operation
- State: pend[WIDTH-1:0] bitmap; output FSM {IDLE, PRESENT}; index_o; valid_o.
- Reset values: pend=0, state=IDLE, index_o=0, valid_o=0, count_o=0, error_o=0.
- Bitmap update each edge: pend <= (pend & ~clr) | (load_i ? vector_i : 0).
  - clr = onehot(index_o) on handshake, else 0.
  - A load of an already-pending bit is idempotent.
  - vector_i=0 has no effect.
  - If a bit is cleared and loaded in the same cycle, the load wins and the bit stays pending.
- IDLE: if pend != 0, latch index_o = lowest set bit of pend, set valid_o=1, go to PRESENT. Otherwise hold.
- PRESENT:
  - index_o and valid_o hold stable until handshake. A newly loaded lower bit does not preempt.
  - On handshake, let rem = pend & ~onehot(index_o).
    - rem != 0: latch lowest set bit of rem, stay in PRESENT (back-to-back issue).
    - rem == 0: valid_o=0, go to IDLE. index_o keeps its last value.
  - Bits loaded in the handshake cycle are not in rem. They are picked up from IDLE on the next cycle.
- ready_i is ignored while valid_o=0.
- count_o = popcount(pend), combinational from the pend register.
- rst_i mid-operation clears everything to reset values at that edge, dropping pending bits. A load_i in the reset cycle is discarded.

## Timing
- Load-to-valid latency: load_i sampled at edge N, pend updated at N, valid_o/index_o high after edge N+1 (2 cycles).
- Throughput: one index per cycle while ready_i=1 and pend holds more than one bit.
- Load arriving with an empty bitmap during the final handshake: one bubble cycle (valid_o=0) before the new index.
- count_o reflects edge-N state in the cycle after edge N. It includes the presented bit until its handshake edge.

## Configuration
- Macro ONEHOT_CHECK_EN.
- Defined:
  - A load_i with popcount(vector_i) != 1 is rejected whole, so pend is unchanged.
  - error_o is 1 for exactly the cycle after the rejected load, registered.
  - vector_i=0 with load_i=1 also counts as a rejected load.
- Undefined: any vector is merged as specified and error_o is tied to 0.

## Test plan
- Reset: assert rst_i for 2 cycles with load_i=1, vector_i=0xFFFF_FFFF -> after release valid_o=0, index_o=0, count_o=0, error_o=0.
- Single: load 0x0000_0008, ready_i=1 -> valid_o=1 with index_o=3 two cycles later, count_o=1. After handshake count_o=0 and valid_o=0.
- Multi-bit (macro off): load 0x8000_0021, ready_i=1 -> index_o 0, 5, 31 on three consecutive cycles, then valid_o=0.
- Backpressure: ready_i=0, load 0x10, then load 0x01 while 4 is presented -> index_o stays 4 and count_o=2. Raise ready_i -> 4, then 0.
- Collision: handshake of index 3 in the same cycle as a load of 0x08 -> bit 3 stays pending, count_o unchanged, index 3 presented again.
- Config on: load 0x0000_0003 -> pend unchanged, error_o=1 for one cycle, valid_o stays 0. Config off: same stimulus -> indices 0, 1.
